// File: rtl/display_controller.sv
// display_controller: bus-programmed 10-digit display driver.
// Converts a signed 32-bit VALUE to BCD (double dabble) or shows it as hex.
// Ports: clk, reset (sync, high); we/addr/wdata bus write; rdata comb read;
//        digits (10x4b, digit 0 lowest), neg, blank (per digit), busy.
module display_controller #(
  parameter bit BLANK_DEFAULT = 1'b0,
  parameter bit HEX_DEFAULT   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [39:0] digits,
  output logic        neg,
  output logic [9:0]  blank,
  output logic        busy
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic        sign_q, sign_d;
  logic        done_q, done_d;
  logic [31:0] value_q, value_d;
  logic        blank_en_q, blank_en_d;
  logic        hex_q, hex_d;
  logic [39:0] digits_q, digits_d;
  logic        neg_q, neg_d;
  logic [9:0]  blank_q, blank_d;

  logic        val_wr;
  logic        ctl_wr;
  logic [31:0] mag;
  logic [35:0] adj_lo;
  logic [2:0]  adj_hi;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    sign_d     = sign_q;
    done_d     = 1'b0;
    value_d    = value_q;
    blank_en_d = blank_en_q;
    hex_d      = hex_q;
    digits_d   = digits_q;
    neg_d      = neg_q;
    blank_d    = '0;

    val_wr = we && (addr == 2'd0);
    ctl_wr = we && (addr == 2'd1);
    mag    = wdata[31] ? (~wdata + 32'd1) : wdata;

    // add-3 on every nibble >= 5 before the shift
    for (int i = 0; i < 9; i++) begin
      adj_lo[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ?
                         bcd_q[4*i +: 4] + 4'd3 :
                         bcd_q[4*i +: 4];
    end
    // top digit's MSB is shifted out, so only its low 3 bits matter
    adj_hi = (bcd_q[39:36] >= 4'd5) ?
             bcd_q[38:36] + 3'd3 :
             bcd_q[38:36];

    if (state_q == CONV) begin
      bcd_d = {adj_hi, adj_lo, bin_q[31]};
      bin_d = {bin_q[30:0], 1'b0};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    // finished result is committed one cycle after the last shift;
    // a VALUE write on that edge supersedes it
    if (done_q && !val_wr) begin
      digits_d = bcd_q;
      neg_d    = sign_q && (bcd_q != 40'd0);
    end

    if (val_wr) begin
      value_d = wdata;
      done_d  = 1'b0;
      if (hex_q) begin
        digits_d = {8'h00, wdata};
        neg_d    = 1'b0;
        state_d  = IDLE;
      end else begin
        state_d = CONV;
        bin_d   = mag;
        bcd_d   = '0;
        cnt_d   = '0;
        sign_d  = wdata[31];
      end
    end

    if (ctl_wr) begin
      blank_en_d = wdata[0];
      hex_d      = wdata[1];
    end

    // leading-zero blanking follows the digits being registered
    if (blank_en_d) begin
      for (int i = 1; i < 10; i++) begin
        blank_d[i] = ((digits_d >> (4*i)) == 40'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      done_q     <= 1'b0;
      value_q    <= '0;
      blank_en_q <= BLANK_DEFAULT;
      hex_q      <= HEX_DEFAULT;
      digits_q   <= '0;
      neg_q      <= 1'b0;
      blank_q    <= BLANK_DEFAULT ? 10'h3FE : 10'h000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      sign_q     <= sign_d;
      done_q     <= done_d;
      value_q    <= value_d;
      blank_en_q <= blank_en_d;
      hex_q      <= hex_d;
      digits_q   <= digits_d;
      neg_q      <= neg_d;
      blank_q    <= blank_d;
    end
  end

  assign busy   = (state_q == CONV);
  assign digits = digits_q;
  assign neg    = neg_q;
  assign blank  = blank_q;

  always_comb begin
    rdata = '0;
    unique case (addr)
      2'd0: rdata = value_q;
      2'd1: rdata = {30'b0, hex_q, blank_en_q};
      2'd2: rdata = {31'b0, busy};
      2'd3: rdata = '0;
    endcase
  end

endmodule

// File: doc/display_controller.md
DISPLAY_CONTROLLER -- requirements
Module: display_controller

Interface
REQ-001 SHALL have parameter BLANK_DEFAULT, default 0: reset value of CTRL.blank.
REQ-002 SHALL have parameter HEX_DEFAULT, default 0: reset value of CTRL.hex.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port we, input, 1: bus write strobe, sampled at rising clk.
REQ-006 SHALL have port addr, input, 2: register select (0 VALUE, 1 CTRL, 2 STATUS, 3 reserved).
REQ-007 SHALL have port wdata, input, 32: bus write data.
REQ-008 SHALL have port rdata, output, 32: combinational read data for addr.
REQ-009 SHALL have port digits, output, 40: ten 4-bit digits; digits[3:0] is least significant.
REQ-010 SHALL have port neg, output, 1: displayed value is negative.
REQ-011 SHALL have port blank, output, 10: bit i=1 means digit i is blanked.
REQ-012 SHALL have port busy, output, 1: conversion in progress.

Function
REQ-013 SHALL implement states IDLE and CONV; IDLE->CONV on a VALUE write in decimal mode; CONV->IDLE after the 32nd shift.
REQ-014 SHALL, on a VALUE write (we=1, addr=0), store wdata in VALUE and, in decimal mode, load |wdata| as 32-bit unsigned plus sign into the converter and clear the iteration counter.
REQ-015 SHALL convert by double dabble: per CONV cycle, add 3 to every BCD nibble >=5, then shift left one bit from the binary register; exactly 32 iterations.
REQ-016 SHALL update digits, neg and blank together, 33 cycles after the VALUE-write edge; busy SHALL be 1 for exactly those 32 cycles after the write edge.
REQ-017 SHALL hold digits, neg and blank stable during CONV (no intermediate values visible).
REQ-018 SHALL treat -2147483648 as magnitude 2147483648 with neg=1.
REQ-019 SHALL force neg=0 when the converted value is zero.
REQ-020 SHALL, on a VALUE write during CONV, abort the current conversion and restart with the new value (busy stays 1; latency counted from the new write).
REQ-021 SHALL, in hex mode (CTRL.hex=1), on a VALUE write update digits[31:0]=wdata, digits[39:32]=0, neg=0 on the next edge, with busy remaining 0.
REQ-022 SHALL, with CTRL.blank=1, set blank[i]=1 for every digit i>=1 above the most significant nonzero digit; digit 0 is never blanked; with CTRL.blank=0, blank=0.
REQ-023 SHALL, on a CTRL write (addr=1), update CTRL.blank=wdata[0], CTRL.hex=wdata[1]; blank SHALL be recomputed from the current digits on the next edge; the mode change SHALL NOT re-convert VALUE.
REQ-024 SHALL, on a CTRL write during CONV, let the conversion finish in the mode it began in.
REQ-025 SHALL return rdata: addr 0 VALUE, addr 1 {30'b0,hex,blank}, addr 2 {31'b0,busy}, addr 3 zero.
REQ-026 SHALL ignore writes to addr 2 and 3.

Reset
REQ-027 SHALL, while reset=1 at a clock edge, set state IDLE, VALUE=0, digits=0, neg=0, busy=0, CTRL={HEX_DEFAULT,BLANK_DEFAULT}, and blank to nine ones above bit 0 if BLANK_DEFAULT=1, else 0.
REQ-028 SHALL, on reset mid-conversion, discard the conversion without updating digits beyond the reset values.
REQ-029 SHALL give reset priority over a simultaneous bus write.

Verification
REQ-030 Write VALUE=-1234, blank=1 -> busy=1 for 32 cycles; at +33 digits=0x0000001234, neg=1, blank=10'b1111110000.
REQ-031 Write VALUE=0x80000000 -> digits=0x2147483648, neg=1, blank=0.
REQ-032 Write 5, then 99 after 10 cycles -> 5 never appears; digits=0x0000000099 33 cycles after the second write.
REQ-033 CTRL.hex=1, write 0xDEADBEEF -> next cycle digits=0x00DEADBEEF, neg=0, busy=0.
REQ-034 Assert reset at cycle 15 of a conversion -> digits=0, busy=0, STATUS reads 0.
REQ-035 Write VALUE=0 with blank=1 -> digits=0, neg=0, blank=10'b1111111110.
